pcm_stream: RTL and testbench

Multichannel PCM playback engine. Host writes interleaved little-endian sample bytes into an internal byte FIFO. A fractional rate accumulator paces whole-frame fetches. Each fetched frame is volume-scaled and presented as NUM_CH parallel signed outputs to the audio mixer. It extends the stereo PCM player with these additions:
- configurable channel count
- atomic frame fetch (no partial-frame misalignment)
- hold-or-zero underrun policy
- sticky underrun status
- FIFO fill level

---
 rtl/pcm_stream.sv | 241 ++++++++++++++++++++++++
 tb/tb_pcm_stream.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pcm_stream.sv
// Multichannel PCM playback engine: byte FIFO, fractional-rate frame pacing,
// atomic whole-frame fetch, channel mapping and log-volume scaling.
module pcm_stream #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4096,
    parameter int RATE_W     = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      next_sample,
    input  logic [RATE_W-1:0]                         sample_rate,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] num_ch,
    input  logic                                      mode_16bit,
    input  logic [3:0]                                volume,
    input  logic                                      hold_on_empty,
    input  logic                                      fifo_reset,
    input  logic [7:0]                                fifo_wrdata,
    input  logic                                      fifo_write,
    output logic                                      fifo_full,
    output logic                                      fifo_almost_empty,
    output logic                                      fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]               fifo_level,
    output logic                                      underrun,
    input  logic                                      underrun_clr,
    output logic                                      frame_valid,
    output logic [NUM_CH*23-1:0]                      audio_out
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);
    localparam logic [LW-1:0]   LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]   LVL_AE   = LW'(FIFO_DEPTH / 4);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FETCH_LO = 2'd1;
    localparam logic [1:0] S_FETCH_HI = 2'd2;
    localparam logic [1:0] S_COMMIT   = 2'd3;

    function automatic logic [6:0] vol_log(input logic [3:0] idx);
        case (idx)
            4'd0:  vol_log = 7'd0;
            4'd1:  vol_log = 7'd1;
            4'd2:  vol_log = 7'd2;
            4'd3:  vol_log = 7'd3;
            4'd4:  vol_log = 7'd4;
            4'd5:  vol_log = 7'd5;
            4'd6:  vol_log = 7'd6;
            4'd7:  vol_log = 7'd8;
            4'd8:  vol_log = 7'd11;
            4'd9:  vol_log = 7'd14;
            4'd10: vol_log = 7'd18;
            4'd11: vol_log = 7'd23;
            4'd12: vol_log = 7'd30;
            4'd13: vol_log = 7'd38;
            4'd14: vol_log = 7'd49;
            default: vol_log = 7'd64;
        endcase
    endfunction

    // Gain is 2*log value (max 128), so the product always fits 23 signed bits.
    function automatic logic signed [22:0] scale(input logic signed [15:0] s,
                                                 input logic [3:0] v);
        logic signed [8:0]  g;
        logic signed [24:0] p;
        g = signed'({1'b0, vol_log(v), 1'b0});
        p = s * g;
        return p[22:0];
    endfunction

    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic [7:0]          rddata_q;
    logic                wr_en, rd_en;

    logic [RATE_W-1:0]   acc_q;
    logic [RATE_W:0]     acc_sum;
    logic                due_q;

    logic [1:0]          state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d, nch_q, nch_d, nch_in;
    logic                m16_q, m16_d;
    logic [LW-1:0]       need_bytes;
    logic signed [15:0]  fbuf_q [NUM_CH];
    logic signed [15:0]  fbuf_d [NUM_CH];
    logic signed [15:0]  samp_q [NUM_CH];
    logic signed [15:0]  samp_d [NUM_CH];
    logic                underrun_q, underrun_d, fv_q, fv_d;
    logic [NUM_CH*23-1:0] audio_q, audio_d;

    assign fifo_full         = (level_q == LVL_FULL);
    assign fifo_empty        = (level_q == '0);
    assign fifo_almost_empty = (level_q < LVL_AE);
    assign fifo_level        = level_q;
    assign underrun          = underrun_q;
    assign frame_valid       = fv_q;
    assign audio_out         = audio_q;

    // A flush also swallows any write presented in the same cycle.
    assign wr_en   = fifo_write && !fifo_full && !fifo_reset;
    assign level_d = level_q + LW'(wr_en) - LW'(rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= fifo_wrdata;
        if (rd_en) rddata_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst || fifo_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    assign acc_sum = {1'b0, acc_q} + {1'b0, sample_rate};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            due_q <= 1'b0;
        end else begin
            due_q <= next_sample && acc_sum[RATE_W];
            if (next_sample) acc_q <= acc_sum[RATE_W-1:0];
        end
    end

    assign nch_in     = (num_ch > CH_MAX) ? CH_MAX : num_ch;
    assign need_bytes = (LW'(nch_in) + LW'(1)) << mode_16bit;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        nch_d      = nch_q;
        m16_d      = m16_q;
        fbuf_d     = fbuf_q;
        samp_d     = samp_q;
        rd_en      = 1'b0;
        fv_d       = 1'b0;
        underrun_d = underrun_q && !underrun_clr;
        if (fifo_reset) begin
            state_d = S_IDLE;
            ch_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (due_q) begin
                        if (level_q >= need_bytes) begin
                            rd_en   = 1'b1;
                            ch_d    = '0;
                            nch_d   = nch_in;
                            m16_d   = mode_16bit;
                            state_d = S_FETCH_LO;
                        end else begin
                            underrun_d = 1'b1;
                            if (!hold_on_empty) begin
                                for (int k = 0; k < NUM_CH; k++) samp_d[k] = '0;
                            end
                        end
                    end
                end
                S_FETCH_LO: begin
                    if (m16_q) begin
                        fbuf_d[ch_q][7:0] = rddata_q;
                        rd_en   = 1'b1;
                        state_d = S_FETCH_HI;
                    end else begin
                        fbuf_d[ch_q] = {rddata_q, 8'h00};
                        if (ch_q < nch_q) begin
                            ch_d  = ch_q + CH_W'(1);
                            rd_en = 1'b1;
                        end else begin
                            state_d = S_COMMIT;
                        end
                    end
                end
                S_FETCH_HI: begin
                    fbuf_d[ch_q][15:8] = rddata_q;
                    if (ch_q < nch_q) begin
                        ch_d    = ch_q + CH_W'(1);
                        rd_en   = 1'b1;
                        state_d = S_FETCH_LO;
                    end else begin
                        state_d = S_COMMIT;
                    end
                end
                default: begin
                    // Mono fans channel 0 out; unused channels go silent.
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (nch_q == '0)
                            samp_d[k] = fbuf_q[0];
                        else if (CH_W'(k) <= nch_q)
                            samp_d[k] = fbuf_q[k];
                        else
                            samp_d[k] = '0;
                    end
                    fv_d    = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        audio_d = '0;
        for (int k = 0; k < NUM_CH; k++) audio_d[23*k +: 23] = scale(samp_q[k], volume);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            nch_q      <= '0;
            m16_q      <= 1'b0;
            underrun_q <= 1'b0;
            fv_q       <= 1'b0;
            audio_q    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                fbuf_q[k] <= '0;
                samp_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            nch_q      <= nch_d;
            m16_q      <= m16_d;
            underrun_q <= underrun_d;
            fv_q       <= fv_d;
            audio_q    <= audio_d;
            fbuf_q     <= fbuf_d;
            samp_q     <= samp_d;
        end
    end

endmodule

// File: tb/tb_pcm_stream.sv
// Directed bench for pcm_stream: expected frames go into a queue that a
// separate monitor drains whenever frame_valid fires.
module tb_pcm_stream;

    localparam int NUM_CH     = 4;
    localparam int FIFO_DEPTH = 4096;
    localparam int RATE_W     = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              next_sample = 1'b0;
    logic [RATE_W-1:0] sample_rate = '0;
    logic [1:0]        num_ch = '0;
    logic              mode_16bit = 1'b0;
    logic [3:0]        volume = '0;
    logic              hold_on_empty = 1'b0;
    logic              fifo_reset = 1'b0;
    logic [7:0]        fifo_wrdata = '0;
    logic              fifo_write = 1'b0;
    logic              fifo_full, fifo_almost_empty, fifo_empty;
    logic [12:0]       fifo_level;
    logic              underrun;
    logic              underrun_clr = 1'b0;
    logic              frame_valid;
    logic [NUM_CH*23-1:0] audio_out;

    int checks = 0;
    int passes = 0;
    int nframes = 0;
    logic [91:0] exp_q[$];

    pcm_stream #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .RATE_W(RATE_W)) dut (
        .clk(clk), .rst(rst), .next_sample(next_sample), .sample_rate(sample_rate),
        .num_ch(num_ch), .mode_16bit(mode_16bit), .volume(volume),
        .hold_on_empty(hold_on_empty), .fifo_reset(fifo_reset),
        .fifo_wrdata(fifo_wrdata), .fifo_write(fifo_write), .fifo_full(fifo_full),
        .fifo_almost_empty(fifo_almost_empty), .fifo_empty(fifo_empty),
        .fifo_level(fifo_level), .underrun(underrun), .underrun_clr(underrun_clr),
        .frame_valid(frame_valid), .audio_out(audio_out)
    );

    always #5 clk = ~clk;

    function automatic logic [91:0] mk(input int c0, input int c1, input int c2, input int c3);
        return {23'(c3), 23'(c2), 23'(c1), 23'(c0)};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        fifo_wrdata = b;
        fifo_write  = 1'b1;
        @(posedge clk);
        #1;
        fifo_write  = 1'b0;
    endtask

    task automatic strobe;
        next_sample = 1'b1;
        @(posedge clk);
        #1;
        next_sample = 1'b0;
    endtask

    // Audio lags the commit by one clock, so compare one cycle after frame_valid.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_valid) begin
                nframes++;
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: got %0h expected none", audio_out);
                end else begin
                    check("frame_audio", {4'b0, audio_out}, {4'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int f0;
        idle(3);
        rst = 1'b0;
        idle(1);
        check("rst_empty", fifo_empty, 1);
        check("rst_aempty", fifo_almost_empty, 1);
        check("rst_level", fifo_level, 0);
        check("rst_underrun", underrun, 0);
        check("rst_audio", audio_out, 0);

        // Stereo 16-bit at full volume
        num_ch = 2'd1; mode_16bit = 1'b1; volume = 4'd15; sample_rate = 8'd128;
        exp_q.push_back(mk(596480, -2759040, 0, 0));
        f0 = nframes;
        wr_byte(8'h34); wr_byte(8'h12); wr_byte(8'hCD); wr_byte(8'hAB);
        check("stereo_level_in", fifo_level, 4);
        strobe(); strobe();
        idle(12);
        check("stereo_frames", nframes - f0, 1);
        check("stereo_level_out", fifo_level, 0);

        // Mono 8-bit, volume index 8 -> gain 22
        num_ch = 2'd0; mode_16bit = 1'b0; volume = 4'd8;
        exp_q.push_back(mk(-720896, -720896, -720896, -720896));
        wr_byte(8'h80);
        check("mono_level_in", fifo_level, 1);
        strobe(); strobe();
        idle(10);
        check("mono_level_out", fifo_level, 0);

        // Underrun: 4ch 16-bit needs 8 bytes, only 7 present
        num_ch = 2'd3; mode_16bit = 1'b1; hold_on_empty = 1'b1;
        for (int i = 0; i < 7; i++) wr_byte(8'(i + 1));
        f0 = nframes;
        strobe(); strobe();
        idle(4);
        check("ur_flag", underrun, 1);
        check("ur_level", fifo_level, 7);
        check("ur_hold_audio", audio_out, mk(-720896, -720896, -720896, -720896));
        hold_on_empty = 1'b0;
        strobe(); strobe();
        idle(4);
        check("ur_zero_audio", audio_out, 0);
        check("ur_level2", fifo_level, 7);
        check("ur_no_frames", nframes - f0, 0);
        underrun_clr = 1'b1;
        idle(1);
        underrun_clr = 1'b0;
        check("ur_clr", underrun, 0);
        fifo_reset = 1'b1;
        idle(1);
        fifo_reset = 1'b0;
        check("flush_level", fifo_level, 0);

        // FIFO boundary: one byte past capacity
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            wr_byte(8'(i));
            if (i == 1022) check("ae_at_1023", fifo_almost_empty, 1);
            if (i == 1023) check("ae_at_1024", fifo_almost_empty, 0);
        end
        check("full_flag", fifo_full, 1);
        check("full_level", fifo_level, FIFO_DEPTH);
        fifo_reset = 1'b1;
        idle(1);
        fifo_reset = 1'b0;
        check("flush_empty", fifo_empty, 1);

        // Mid-fetch abort in FETCH_HI
        num_ch = 2'd1; mode_16bit = 1'b1; volume = 4'd15;
        exp_q.push_back(mk(596480, -2759040, 0, 0));
        wr_byte(8'h34); wr_byte(8'h12); wr_byte(8'hCD); wr_byte(8'hAB);
        strobe(); strobe();
        idle(10);
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
        f0 = nframes;
        strobe(); strobe();
        idle(2);
        fifo_reset = 1'b1;
        idle(1);
        fifo_reset = 1'b0;
        check("abort_level", fifo_level, 0);
        idle(8);
        check("abort_no_frame", nframes - f0, 0);
        check("abort_audio", audio_out, mk(596480, -2759040, 0, 0));

        // Accumulator wrap: rate 0x40 over 8 strobes -> 2 frames
        num_ch = 2'd0; mode_16bit = 1'b0; sample_rate = 8'h40;
        exp_q.push_back(mk(4161536, 4161536, 4161536, 4161536));
        exp_q.push_back(mk(32768, 32768, 32768, 32768));
        wr_byte(8'h7F); wr_byte(8'h01); wr_byte(8'h55);
        f0 = nframes;
        for (int i = 0; i < 8; i++) begin
            strobe();
            idle(5);
        end
        check("wrap_frames", nframes - f0, 2);
        check("wrap_level", fifo_level, 1);
        check("queue_drained", exp_q.size(), 0);

        idle(5);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
